// File: rtl/solitaire_pkg.sv
// Shared constants, FSM state type and frame-bit selection for the board shifter.
// Frame layout: 7 padding zeros, then holes 32 down to 0, index 0 shifted first.
package solitaire_pkg;

  localparam int BOARD_HOLES = 33;
  localparam int FRAME_BITS  = 40;
  localparam int PAD_BITS    = 7;
  localparam int IDX_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [BOARD_HOLES-1:0] board;
    logic [IDX_W-1:0]       cursor;
    logic                   cursor_valid;
    logic                   blink;
  } snap_t;

  // Frame index i >= PAD_BITS carries hole (FRAME_BITS-1-i); the cursor hole blinks.
  function automatic logic frame_bit(input snap_t s, input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] hole;
    logic             hit;
    frame_bit = 1'b0;
    hole      = IDX_W'(FRAME_BITS - 1) - idx;
    hit       = s.cursor_valid && s.blink && (s.cursor == hole) &&
                (s.cursor < IDX_W'(BOARD_HOLES));
    if (idx >= IDX_W'(PAD_BITS) && idx < IDX_W'(FRAME_BITS))
      frame_bit = s.board[hole] ^ hit;
  endfunction

endpackage

// File: rtl/solitaire_phase_timer.sv
// Purpose: CLK_DIV-cycle phase down-counter; load restarts a phase, expire marks its last cycle.
// Latency: expire is combinational, asserted on the CLK_DIV-th enabled cycle after load.
// Backpressure: ena=0 freezes the count and suppresses expire.
module solitaire_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (ena) begin
      if (load)
        cnt <= 4'(CLK_DIV - 1);
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  assign expire = ena && (cnt == 4'd0);

endmodule

// File: rtl/solitaire_board_shifter.sv
// Purpose: serialises a 33-hole peg board (with blinking cursor) into a 74HC595 chain.
// Latency: busy 1 cycle after start, done at 1+81*CLK_DIV; registered outputs.
// Backpressure: start only accepted in IDLE; ena=0 freezes every register.
module solitaire_board_shifter
  import solitaire_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [BOARD_HOLES-1:0] board,
  input  logic [IDX_W-1:0]       cursor,
  input  logic                   cursor_valid,
  output logic                   sr_data,
  output logic                   sr_clk,
  output logic                   sr_latch,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [BLINK_BITS-1:0] blink_cnt;
  snap_t                 snap, snap_nxt;
  logic                  load, capture, expire;
  logic                  sr_data_nxt, sr_clk_nxt, sr_latch_nxt, busy_nxt, done_nxt;

  solitaire_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .load   (load),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      blink_cnt <= '0;
      snap      <= '0;
      sr_data   <= 1'b0;
      sr_clk    <= 1'b0;
      sr_latch  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (ena) begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
      snap      <= snap_nxt;
      sr_data   <= sr_data_nxt;
      sr_clk    <= sr_clk_nxt;
      sr_latch  <= sr_latch_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    capture   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (expire) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (expire) begin
          load = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = ST_LATCH;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ST_SHIFT_LO;
          end
        end
      end
      ST_LATCH: begin
        if (expire)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // The snapshot is taken in the same cycle the first bit is decoded, so bypass it.
    snap_nxt = snap;
    if (capture) begin
      snap_nxt.board        = board;
      snap_nxt.cursor       = cursor;
      snap_nxt.cursor_valid = cursor_valid;
      snap_nxt.blink        = blink_cnt[BLINK_BITS-1];
    end

    // Outputs are decoded from the next state so they register glitch-free.
    sr_clk_nxt   = (state_nxt == ST_SHIFT_HI);
    sr_latch_nxt = (state_nxt == ST_LATCH);
    done_nxt     = (state_nxt == ST_DONE);
    busy_nxt     = (state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI) ||
                   (state_nxt == ST_LATCH);
    sr_data_nxt  = 1'b0;
    if ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI))
      sr_data_nxt = frame_bit(snap_nxt, idx_nxt);
  end

endmodule

// File: tb/tb_solitaire_board_shifter.sv
// Directed + randomized bench for solitaire_board_shifter; two instances cover CLK_DIV=2 and CLK_DIV=1.
module tb_solitaire_board_shifter;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, sel_b;
  logic [32:0] board;
  logic [5:0]  cursor;
  logic        cursor_valid;
  logic        start_a, start_b;
  logic        a_data, a_clk, a_latch, a_busy, a_done;
  logic        b_data, b_clk, b_latch, b_busy, b_done;
  logic        o_data, o_clk, o_latch, o_busy, o_done;
  int          checks = 0;
  int          errors = 0;
  int          ena_edges;

  always #5 clk = ~clk;

  assign start_a = start && !sel_b;
  assign start_b = start && sel_b;
  assign o_data  = sel_b ? b_data  : a_data;
  assign o_clk   = sel_b ? b_clk   : a_clk;
  assign o_latch = sel_b ? b_latch : a_latch;
  assign o_busy  = sel_b ? b_busy  : a_busy;
  assign o_done  = sel_b ? b_done  : a_done;

  solitaire_board_shifter #(.CLK_DIV(2), .BLINK_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_a), .board(board),
    .cursor(cursor), .cursor_valid(cursor_valid), .sr_data(a_data), .sr_clk(a_clk),
    .sr_latch(a_latch), .busy(a_busy), .done(a_done)
  );

  solitaire_board_shifter #(.CLK_DIV(1), .BLINK_BITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .board(board),
    .cursor(cursor), .cursor_valid(cursor_valid), .sr_data(b_data), .sr_clk(b_clk),
    .sr_latch(b_latch), .busy(b_busy), .done(b_done)
  );

  // Number of enabled clock edges since reset: the blink counter's value by definition.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ena_edges <= 0;
    else if (ena) ena_edges <= ena_edges + 1;
  end

  function automatic int phase_of(input int cnt, input int bb);
    return ((cnt % (1 << bb)) >> (bb - 1)) & 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input bit use_b, input logic [32:0] b,
                           input logic [5:0] cur, input logic cv, input int want_phase,
                           input bit hold, input int freeze_at, input int abort_at);
    int          div, bb, phase, budget, f_len, h;
    int          first_rise, latch_first, latch_last, done_cyc, done2_cyc, n_done, n_rise;
    logic [39:0] exp_bits, got_bits;
    logic [63:0] rnd;
    logic        prev_clk;
    sel_b = use_b;
    div   = use_b ? 1 : 2;
    bb    = use_b ? 3 : 1;
    @(posedge clk); #1;
    for (int k = 0; k < 8 && want_phase >= 0 && phase_of(ena_edges, bb) != want_phase; k++) begin
      @(posedge clk); #1;
    end
    phase        = phase_of(ena_edges, bb);
    board        = b;
    cursor       = cur;
    cursor_valid = cv;
    start        = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i < 7) begin
        exp_bits[i] = 1'b0;
      end else begin
        h = 39 - i;
        exp_bits[i] = b[h] ^ (cv && int'(cur) == h && cur < 6'd33 && phase == 1);
      end
    end
    f_len       = (freeze_at >= 0) ? 10 : 0;
    budget      = 81 * div + f_len + (hold ? 81 * div + 10 : 0) + 20;
    first_rise  = -1; latch_first = -1; latch_last = -1;
    done_cyc    = -1; done2_cyc = -1; n_done = 0; n_rise = 0;
    prev_clk    = 1'b0;
    got_bits    = '0;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        // Inputs change freely after capture; the frame must come from the snapshot.
        rnd          = {$urandom(), $urandom()};
        board        = rnd[32:0];
        cursor       = rnd[38:33];
        cursor_valid = rnd[39];
        if (!hold || (done_cyc >= 0 && cyc > done_cyc + 1)) start = 1'b0;
        ena = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 10);
        if (abort_at >= 0 && cyc == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk({tag, " abort sr_clk"}, 64'(o_clk), 64'd0);
          chk({tag, " abort busy"}, 64'(o_busy), 64'd0);
        end
        if (abort_at >= 0 && cyc == abort_at + 3) rst_n = 1'b1;
      end
      @(negedge clk);
      if (cyc == 1) chk({tag, " busy at cycle 1"}, 64'(o_busy), 64'd1);
      if (o_clk && !prev_clk) begin
        if (n_rise < 40) got_bits[n_rise] = o_data;
        if (first_rise < 0) first_rise = cyc;
        n_rise++;
      end
      prev_clk = o_clk;
      if (freeze_at >= 0 && cyc == freeze_at + 9)
        chk({tag, " sr_clk held in freeze"}, 64'(o_clk), 64'd1);
      if (o_latch && done_cyc < 0) begin
        if (latch_first < 0) latch_first = cyc;
        latch_last = cyc;
      end
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk({tag, " busy low in done"}, 64'(o_busy), 64'd0);
        end else if (done2_cyc < 0) begin
          done2_cyc = cyc;
        end
      end
      if (hold && done_cyc >= 0 && cyc == done_cyc + 1)
        chk({tag, " idle after done"}, 64'(o_busy), 64'd0);
      if (hold && done_cyc >= 0 && cyc == done_cyc + 2)
        chk({tag, " restart busy"}, 64'(o_busy), 64'd1);
    end
    start = 1'b0;
    ena   = 1'b1;
    if (abort_at >= 0) begin
      chk({tag, " no done after abort"}, 64'(n_done), 64'd0);
      chk({tag, " outputs idle after abort"},
          64'({o_data, o_clk, o_latch, o_busy, o_done}), 64'd0);
    end else begin
      chk({tag, " frame bits"}, 64'(got_bits), 64'(exp_bits));
      chk({tag, " first sr_clk rise"}, 64'(first_rise), 64'(1 + div));
      chk({tag, " latch first"}, 64'(latch_first), 64'(1 + 80 * div + f_len));
      chk({tag, " latch last"}, 64'(latch_last), 64'(81 * div + f_len));
      chk({tag, " done cycle"}, 64'(done_cyc), 64'(1 + 81 * div + f_len));
      if (hold) begin
        chk({tag, " second done"}, 64'(done2_cyc), 64'(done_cyc + 2 + 81 * div));
        chk({tag, " done count"}, 64'(n_done), 64'd2);
      end else begin
        chk({tag, " done count"}, 64'(n_done), 64'd1);
      end
    end
  endtask

  initial begin
    logic [63:0] rnd;
    logic [5:0]  rc;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; sel_b = 1'b0;
    board = '0; cursor = '0; cursor_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({a_data, a_clk, a_latch, a_busy, a_done,
                              b_data, b_clk, b_latch, b_busy, b_done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame("basic", 1'b0, 33'h1_FFFF_FFFE, 6'd0, 1'b0, -1, 1'b0, -1, -1);
    run_frame("blink on", 1'b0, 33'h0, 6'd16, 1'b1, 1, 1'b0, -1, -1);
    run_frame("blink off", 1'b0, 33'h0, 6'd16, 1'b1, 0, 1'b0, -1, -1);
    run_frame("start held", 1'b0, 33'h0_A5A5_5A5A, 6'd3, 1'b1, 1, 1'b1, -1, -1);
    run_frame("cursor 40", 1'b0, 33'h1_2345_6789, 6'd40, 1'b1, 1, 1'b0, -1, -1);
    // Cycle 4 is the second cycle of the first SHIFT_HI at CLK_DIV=2.
    run_frame("freeze", 1'b0, 33'h0_F0F0_0F0F, 6'd32, 1'b1, 1, 1'b0, 4, -1);
    // Cycle 51 lands in a SHIFT_HI phase, so sr_clk is high just before reset.
    run_frame("abort", 1'b0, 33'h1_FFFF_FFFF, 6'd0, 1'b0, -1, 1'b0, -1, 51);
    run_frame("after abort", 1'b0, 33'h0_1357_9BDF, 6'd0, 1'b1, 1, 1'b0, -1, -1);
    run_frame("div1", 1'b1, 33'h0_0000_0001, 6'd0, 1'b0, -1, 1'b0, -1, -1);
    run_frame("div1 blink", 1'b1, 33'h1_0000_0000, 6'd32, 1'b1, 1, 1'b0, -1, -1);

    for (int n = 0; n < 6; n++) begin
      rnd = {$urandom(), $urandom()};
      rc  = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 32)) : 6'($urandom_range(33, 63));
      run_frame($sformatf("rand%0d", n), n[0], rnd[32:0], rc, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), 1'b0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
